// File: rtl/rock_drive_pkg.sv
// Shared types and constants for the cradle drive stage: FSM states, level
// widths and the amplitude-to-duty mapping.
package rock_drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWING_L = 2'd1,
    SWING_R = 2'd2,
    BRAKE   = 2'd3
  } state_t;

  localparam int LVL_W    = 4;
  localparam int LVL_MAX  = 15;
  localparam int FREQ_MIN = 1;
  localparam int PWM_W    = 8;

  // 17*lvl spreads 0..15 evenly over 0..255 so full amplitude is 255/256 high
  function automatic logic [PWM_W-1:0] duty_of(input logic [LVL_W-1:0] lvl);
    return PWM_W'(PWM_W'(lvl) * PWM_W'(17));
  endfunction

endpackage

// File: rtl/rock_drive_if.sv
// Command levels from the rocking-control FSM and the motor drive pins.
interface rock_drive_if;
  import rock_drive_pkg::*;

  logic             Fplus;
  logic             Fmin;
  logic             Amin;
  logic             motor_en;
  logic             motor_dir;
  logic             motor_pwm;
  logic [LVL_W-1:0] freq_lvl;
  logic [LVL_W-1:0] amp_lvl;

  modport master (
    output Fplus, Fmin, Amin,
    input  motor_en, motor_dir, motor_pwm, freq_lvl, amp_lvl
  );

  modport slave (
    input  Fplus, Fmin, Amin,
    output motor_en, motor_dir, motor_pwm, freq_lvl, amp_lvl
  );

endinterface

// File: rtl/rock_pwm.sv
// Free-running PWM: registered compare of an 8-bit counter against duty.
module rock_pwm
  import rock_drive_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm
);

  logic [PWM_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      pwm <= en && (cnt < duty);
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Library 2-FF synchroniser cell for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic d_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_p0 <= 1'b0;
      q    <= 1'b0;
    end else begin
      d_p0 <= d;
      q    <= d_p0;
    end
  end

endmodule

// File: rtl/rock_drive.sv
// Cradle motor drive: turns Fplus/Fmin/Amin command levels into saturating
// frequency/amplitude levels and alternating, amplitude-scaled half-swings.
module rock_drive
  import rock_drive_pkg::*;
#(
  parameter int TICK_DIV    = 1000000,
  parameter int PERIOD_UNIT = 50000,
  parameter int FREQ_INIT   = 8,
  parameter int AMP_INIT    = 8,
  parameter int BRAKE_CYC   = 1000
) (
  input  logic          clk,
  input  logic          reset,
  rock_drive_if.slave   bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int PH_W  = $clog2(PERIOD_UNIT * LVL_MAX + 1);
  localparam int BRK_W = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;

  function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] v);
    return (v >= LVL_W'(LVL_MAX)) ? LVL_W'(LVL_MAX) : v + LVL_W'(1);
  endfunction

  function automatic logic [LVL_W-1:0] sat_dec(input logic [LVL_W-1:0] v,
                                               input logic [LVL_W-1:0] floor_v);
    return (v <= floor_v) ? floor_v : v - LVL_W'(1);
  endfunction

  // Product never exceeds PERIOD_UNIT*15, which PH_W is sized to hold
  function automatic logic [PH_W-1:0] half_period(input logic [LVL_W-1:0] lvl);
    return PH_W'(PERIOD_UNIT) * PH_W'(LVL_MAX + 1 - int'(lvl));
  endfunction

  logic             fplus_s, fmin_s, amin_s;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [LVL_W-1:0] pend_f, pend_a, pend_f_nxt, pend_a_nxt;
  state_t           state, state_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic [BRK_W-1:0] brk_cnt, brk_cnt_nxt;
  logic [LVL_W-1:0] freq_q, amp_q, freq_nxt, amp_nxt;
  logic             boundary;
  logic             swing;
  logic [PWM_W-1:0] duty;

  // Stage p0/p1: command synchronisers
  sync_2ff u_sync_fplus (.clk(clk), .reset(reset), .d(bus.Fplus), .q(fplus_s));
  sync_2ff u_sync_fmin  (.clk(clk), .reset(reset), .d(bus.Fmin),  .q(fmin_s));
  sync_2ff u_sync_amin  (.clk(clk), .reset(reset), .d(bus.Amin),  .q(amin_s));

  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_cnt <= '0;
    else        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
  end

  // Pending levels; the next-values feed the loads so a coincident tick wins
  always_comb begin
    pend_f_nxt = pend_f;
    pend_a_nxt = pend_a;
    if (tick) begin
      if (fplus_s && !fmin_s)      pend_f_nxt = sat_inc(pend_f);
      else if (fmin_s && !fplus_s) pend_f_nxt = sat_dec(pend_f, LVL_W'(FREQ_MIN));
      pend_a_nxt = amin_s ? sat_dec(pend_a, LVL_W'(0)) : sat_inc(pend_a);
    end
  end

  assign boundary = (phase == half_period(freq_q) - PH_W'(1));

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    brk_cnt_nxt = brk_cnt;
    freq_nxt    = freq_q;
    amp_nxt     = amp_q;
    case (state)
      IDLE: begin
        if (tick && (pend_a_nxt != '0)) begin
          freq_nxt  = pend_f_nxt;
          amp_nxt   = pend_a_nxt;
          phase_nxt = '0;
          state_nxt = SWING_L;
        end
      end
      SWING_L, SWING_R: begin
        phase_nxt = phase + PH_W'(1);
        if (boundary) begin
          freq_nxt  = pend_f_nxt;
          amp_nxt   = pend_a_nxt;
          phase_nxt = '0;
          if (pend_a_nxt == '0) begin
            brk_cnt_nxt = '0;
            state_nxt   = BRAKE;
          end else begin
            state_nxt = (state == SWING_L) ? SWING_R : SWING_L;
          end
        end
      end
      BRAKE: begin
        brk_cnt_nxt = brk_cnt + BRK_W'(1);
        if (brk_cnt == BRK_W'(BRAKE_CYC - 1)) begin
          brk_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      brk_cnt <= '0;
      freq_q  <= LVL_W'(FREQ_INIT);
      amp_q   <= LVL_W'(AMP_INIT);
      pend_f  <= LVL_W'(FREQ_INIT);
      pend_a  <= LVL_W'(AMP_INIT);
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      brk_cnt <= brk_cnt_nxt;
      freq_q  <= freq_nxt;
      amp_q   <= amp_nxt;
      pend_f  <= pend_f_nxt;
      pend_a  <= pend_a_nxt;
    end
  end

  assign swing = (state == SWING_L) || (state == SWING_R);
  assign duty  = duty_of(amp_q);

  // Output stage: every pin is one register behind state and levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.motor_en  <= 1'b0;
      bus.motor_dir <= 1'b0;
      bus.freq_lvl  <= LVL_W'(FREQ_INIT);
      bus.amp_lvl   <= LVL_W'(AMP_INIT);
    end else begin
      bus.motor_en <= swing;
      if (state == SWING_L)      bus.motor_dir <= 1'b0;
      else if (state == SWING_R) bus.motor_dir <= 1'b1;
      bus.freq_lvl <= freq_q;
      bus.amp_lvl  <= amp_q;
    end
  end

  rock_pwm u_pwm (
    .clk   (clk),
    .reset (reset),
    .en    (swing),
    .duty  (duty),
    .pwm   (bus.motor_pwm)
  );

endmodule

// File: tb/tb_rock_drive.sv
// Bench for rock_drive: phase table, corner sequences and random commands,
// all checked against a cycle-level behavioural model of the drive.
module tb_rock_drive;

  localparam int TICK_DIV    = 4;
  localparam int PERIOD_UNIT = 2;
  localparam int FREQ_INIT   = 8;
  localparam int AMP_INIT    = 8;
  localparam int BRAKE_CYC   = 3;
  localparam logic [10:0] RST_PINS = {3'b000, 4'(FREQ_INIT), 4'(AMP_INIT)};

  logic clk = 1'b0;
  logic reset = 1'b1;

  rock_drive_if bus ();

  rock_drive #(
    .TICK_DIV    (TICK_DIV),
    .PERIOD_UNIT (PERIOD_UNIT),
    .FREQ_INIT   (FREQ_INIT),
    .AMP_INIT    (AMP_INIT),
    .BRAKE_CYC   (BRAKE_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  logic [10:0] pins;
  assign pins = {bus.motor_en, bus.motor_dir, bus.motor_pwm, bus.freq_lvl, bus.amp_lvl};

  // Behavioural model: mode 0 idle, 1 swinging, 2 braking; m_left counts the
  // clocks remaining in the current swing or brake.
  int          m_tcnt, m_pf, m_pa, m_freq, m_amp, m_mode, m_side, m_left, m_cyc;
  logic [2:0]  m_s1, m_s2;
  logic        m_dir;
  logic [10:0] exp_pins;

  always @(posedge clk or negedge reset) begin : model
    bit tick, en, dir;
    int pf, pa, fr, am, mode, side, left;
    if (!reset) begin
      m_tcnt <= 0; m_pf <= FREQ_INIT; m_pa <= AMP_INIT;
      m_freq <= FREQ_INIT; m_amp <= AMP_INIT;
      m_mode <= 0; m_side <= 0; m_left <= 0; m_cyc <= 0;
      m_s1 <= '0; m_s2 <= '0; m_dir <= 1'b0;
      exp_pins <= RST_PINS;
    end else begin
      tick = (m_tcnt == TICK_DIV - 1);
      m_tcnt <= tick ? 0 : m_tcnt + 1;
      m_s1 <= {bus.Fplus, bus.Fmin, bus.Amin};
      m_s2 <= m_s1;
      pf = m_pf; pa = m_pa;
      if (tick) begin
        if (m_s2[2] && !m_s2[1])      pf = (pf < 15) ? pf + 1 : 15;
        else if (m_s2[1] && !m_s2[2]) pf = (pf > 1) ? pf - 1 : 1;
        pa = m_s2[0] ? ((pa > 0) ? pa - 1 : 0) : ((pa < 15) ? pa + 1 : 15);
      end
      m_pf <= pf; m_pa <= pa;
      en  = (m_mode == 1);
      dir = en ? (m_side != 0) : m_dir;
      exp_pins <= {en, dir, en && ((m_cyc % 256) < m_amp * 17), 4'(m_freq), 4'(m_amp)};
      m_dir <= dir;
      m_cyc <= m_cyc + 1;
      fr = m_freq; am = m_amp; mode = m_mode; side = m_side; left = m_left;
      if (mode == 0) begin
        if (tick && pa > 0) begin
          fr = pf; am = pa; mode = 1; side = 0; left = PERIOD_UNIT * (16 - fr);
        end
      end else if (mode == 1) begin
        left = left - 1;
        if (left == 0) begin
          fr = pf; am = pa;
          if (am == 0) begin mode = 2; left = BRAKE_CYC; end
          else begin side = 1 - side; left = PERIOD_UNIT * (16 - fr); end
        end
      end else begin
        left = left - 1;
        if (left == 0) mode = 0;
      end
      m_freq <= fr; m_amp <= am; m_mode <= mode; m_side <= side; m_left <= left;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
    if (reset) check("pins", int'(pins), int'(exp_pins));
  endtask

  task automatic set_in(input logic fp, input logic fm, input logic am);
    bus.Fplus = fp; bus.Fmin = fm; bus.Amin = am;
  endtask

  typedef struct {
    logic fp, fm, am;
    int   cycles;
    int   exp_en, exp_freq, exp_amp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, hi;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 200, 1, 10, 15};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 200, 1, 15, 15};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 100, 1, 15, 15};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 400, 1,  1, 15};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 400, 0,  1,  0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 200, 1,  1, 15};

    set_in(0, 0, 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", int'(pins), int'(RST_PINS));
    reset = 1'b1;

    // First tick leaves IDLE with amp raised to 9
    n = 0;
    while (!bus.motor_en && n < 50) begin cyc(); n++; end
    check("first_swing_en", int'(bus.motor_en), 1);
    check("first_swing_amp", int'(bus.amp_lvl), 9);
    check("first_swing_dir", int'(bus.motor_dir), 0);

    // Fplus pulse spanning two ticks mid-swing: freq holds until the flip
    set_in(1, 0, 0);
    repeat (8) begin cyc(); check("midswing_freq_hold", int'(bus.freq_lvl), 8); end
    set_in(0, 0, 0);
    n = 0;
    while (!bus.motor_dir && n < 40) begin
      check("midswing_freq_hold", int'(bus.freq_lvl), 8);
      cyc(); n++;
    end
    check("flip_dir", int'(bus.motor_dir), 1);
    check("flip_freq", int'(bus.freq_lvl), 10);

    foreach (tbl[i]) begin
      set_in(tbl[i].fp, tbl[i].fm, tbl[i].am);
      repeat (tbl[i].cycles) cyc();
      check($sformatf("tbl%0d_en", i),   int'(bus.motor_en), tbl[i].exp_en);
      check($sformatf("tbl%0d_freq", i), int'(bus.freq_lvl), tbl[i].exp_freq);
      check($sformatf("tbl%0d_amp", i),  int'(bus.amp_lvl),  tbl[i].exp_amp);
    end

    // Full amplitude, steady swing: 255 of every 256 cycles high
    hi = 0;
    repeat (256) begin cyc(); hi += int'(bus.motor_pwm); end
    check("pwm_full_count", hi, 255);

    // Asynchronous reset in the middle of a right swing
    n = 0;
    while (!(bus.motor_en && bus.motor_dir) && n < 200) begin cyc(); n++; end
    check("reach_swing_r", int'({bus.motor_en, bus.motor_dir}), 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset_pins", int'(pins), int'(RST_PINS));
    repeat (2) @(negedge clk);
    check("held_reset_pins", int'(pins), int'(RST_PINS));
    reset = 1'b1;
    n = 0;
    while (!bus.motor_en && n < 50) begin cyc(); n++; end
    check("restart_en", int'(bus.motor_en), 1);
    check("restart_freq", int'(bus.freq_lvl), 8);
    check("restart_amp", int'(bus.amp_lvl), 9);
    check("restart_dir", int'(bus.motor_dir), 0);

    // Random commands, then a run biased towards lowering amplitude
    for (int k = 0; k < 250; k++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 12)) cyc();
    end
    for (int k = 0; k < 250; k++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(1, 12)) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rock_drive.md
Name: rock_drive

Overview:
- Downstream stage of the rocking-control FSM; consumes its Fplus/Fmin/Amin command levels.
- Converts commands into saturating frequency and amplitude levels.
- Generates the cradle motor drive from those levels: alternating direction half-swings, amplitude-scaled PWM, and brake/idle handling.

Parameters:
TICK_DIV, 1000000, clk cycles between command samples (prescaler period, >=2)
PERIOD_UNIT, 50000, clk cycles per half-period step; half-period = PERIOD_UNIT*(16-freq_lvl)
FREQ_INIT, 8, freq_lvl after reset (1..15)
AMP_INIT, 8, amp_lvl after reset (0..15)
BRAKE_CYC, 1000, clk cycles spent in BRAKE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Fplus  in  1  raise-frequency command level (asynchronous to clk domain logic; synchronise)
Fmin  in  1  lower-frequency command level (synchronise)
Amin  in  1  1 = lower amplitude, 0 = raise amplitude (synchronise)
motor_en  out  1  motor driver enable
motor_dir  out  1  0 = left swing, 1 = right swing
motor_pwm  out  1  PWM drive
freq_lvl  out  4  current applied frequency level
amp_lvl  out  4  current applied amplitude level

Behaviour:
- Reset (reset=0, async): state IDLE; motor_en=0, motor_dir=0, motor_pwm=0; freq_lvl=FREQ_INIT, amp_lvl=AMP_INIT; all counters 0; synchronisers 0.
- Inputs: each passes a 2-FF synchroniser; decisions use the synchronised value.
- Prescaler: counts 0..TICK_DIV-1; tick is a 1-cycle pulse when count=TICK_DIV-1, then wraps.
- On tick, pending levels are computed from the synchronised inputs:
  - Fplus & !Fmin: pend_f = min(pend_f+1, 15).
  - Fmin & !Fplus: pend_f = max(pend_f-1, 1).
  - Both or neither: pend_f holds.
  - Amin=1: pend_a = max(pend_a-1, 0). Amin=0: pend_a = min(pend_a+1, 15).
- Applied levels: freq_lvl/amp_lvl load from pend_f/pend_a only at a half-period boundary or on IDLE exit. No mid-swing change.
- FSM states: IDLE, SWING_L, SWING_R, BRAKE.
  - IDLE: motor_en=0. When pend_a>0 at a tick: load levels, go SWING_L, phase counter=0.
  - SWING_L/SWING_R: motor_en=1, motor_dir=0/1. Phase counter increments each clk.
  - At phase = PERIOD_UNIT*(16-freq_lvl)-1 (boundary), load levels:
    - If the new amp_lvl=0: go BRAKE.
    - Otherwise go to the opposite swing state with phase=0.
  - BRAKE: motor_en=0, motor_pwm=0, motor_dir held. After BRAKE_CYC cycles go IDLE.
  - A tick coincident with a boundary: the pending update happens first, and the boundary loads the updated value.
- PWM: free-running 8-bit counter. duty = amp_lvl*17 (0..255). motor_pwm = motor_en & (pwm_cnt < duty). amp_lvl=15 gives 255/256 high.
- Widths: phase counter sized for PERIOD_UNIT*15 (use $clog2). The multiply is done in a width that does not overflow.
- Outputs are registered; 1-cycle latency from state/level change to pins.

Decomposition:
- Shared package: state enum (IDLE, SWING_L, SWING_R, BRAKE), LVL_W=4, LVL_MAX=15, FREQ_MIN=1, PWM_W=8.
- One sub-module: rock_pwm (8-bit counter + compare, inputs en/duty, output pwm).
- The synchroniser is a reusable 2-FF cell already in the library.

Test Plan (bench params TICK_DIV=4, PERIOD_UNIT=2, BRAKE_CYC=3, FREQ_INIT=8, AMP_INIT=8):
- Reset release, all inputs 0:
  - Amin=0 raises pend_a, so the first tick leaves IDLE with amp_lvl=9.
  - SWING_L lasts 16 clks (2*8), then motor_dir toggles to 1.
- Fplus=1 held 10 ticks: pend_f saturates at 15; after the next boundary, freq_lvl=15 and half-period=2 clks. Fplus=Fmin=1 holds freq_lvl.
- Fmin=1 held 20 ticks: freq_lvl floors at 1, half-period=30 clks, never 0.
- Amin=1 held from amp_lvl=8:
  - Level decrements per tick; PWM high count per 256 cycles follows 17*amp_lvl.
  - At a boundary with amp 0: motor_en=0 for 3 clks (BRAKE), then IDLE.
  - Amin=0 restarts SWING_L at the next tick.
- Level change mid-swing: Fplus pulse during SWING_L; freq_lvl output unchanged until the boundary, then updates in the same cycle motor_dir flips.
- Async reset asserted mid-SWING_R:
  - Outputs go to reset values immediately, without waiting for a clk edge.
  - After release, the sequence restarts from IDLE with freq_lvl=8.
